// File: rtl/tube_bcd_formatter.sv
// -----------------------------------------------------------------------------
// tube_bcd_formatter
//   Formats a 32-bit CPU value into the 8-nibble show_data word for the 8-digit
//   seven-segment tube driver. Hex mode passes the value straight through.
//   Decimal mode runs a double-dabble conversion, one input bit per clock.
//   show_data and ovf are registers that change only when the FSM enters DONE
//   (or on reset), so the tube never sees partial conversion results.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous reset, active low
//   start       in   1   conversion request, sampled only in IDLE
//   mode        in   1   0 = hex passthrough, 1 = decimal (BCD)
//   bin_in      in   32  value to format, latched on the accepted start
//   busy        out  1   high while in CONV or DONE
//   done        out  1   one-cycle pulse, coincides with the new show_data/ovf
//   ovf         out  1   last request was a decimal value >= DEC_LIMIT
//   show_data   out  32  nibble k = digit k, digit 0 rightmost
//   dbg_state_o out  2   current FSM state (0 IDLE, 1 CONV, 2 DONE)
//
// Handshake: a request is accepted on a rising clk edge where the FSM is IDLE
// and start=1. start is ignored while busy=1 (including the DONE cycle), and
// a start held high re-triggers on every IDLE edge. done=1 marks the single
// cycle in which the result of the accepted request is first visible.
// -----------------------------------------------------------------------------
module tube_bcd_formatter #(
  parameter int unsigned DEC_LIMIT = 100_000_000,
  parameter int unsigned NBITS     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [NBITS-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [31:0]      show_data,
  output logic [1:0]       dbg_state_o
);

  localparam int unsigned CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NBITS - 1);
  localparam logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      bcd_q, bcd_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      show_q, show_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             over_limit;
  logic             last_step;
  logic [31:0]      bcd_adj;
  logic [31:0]      bcd_step;

  assign accept     = (state_q == S_IDLE) && start;
  // Widen both sides so the limit compare is safe for any NBITS.
  assign over_limit = 64'(bin_in) >= 64'(DEC_LIMIT);
  assign last_step  = (cnt_q == LAST_STEP);

  // Double-dabble step: add-3 correction on every digit >= 5, then shift the
  // next input bit in from the bottom. Correction precedes the shift on every
  // step; with inputs below DEC_LIMIT nothing ever carries out of digit 7.
  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < 8; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end else begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4];
      end
    end
    bcd_step = {bcd_adj[30:0], sh_q[NBITS-1]};
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      show_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      show_q  <= show_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (mode && !over_limit) state_d = S_CONV;
          else                     state_d = S_DONE;
        end
      end
      S_CONV: begin
        if (last_step) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values. show/ovf are only written on the transition into
  // DONE, which is what keeps the display frozen during CONV.
  always_comb begin
    bcd_d  = bcd_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    show_d = show_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!mode) begin
            show_d = 32'(bin_in);
            ovf_d  = 1'b0;
          end else if (over_limit) begin
            show_d = OVF_PATTERN;
            ovf_d  = 1'b1;
          end else begin
            bcd_d = '0;
            sh_d  = bin_in;
            cnt_d = '0;
          end
        end
      end
      S_CONV: begin
        bcd_d = bcd_step;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          show_d = bcd_step;
          ovf_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    ovf         = ovf_q;
    show_data   = show_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_tube_bcd_formatter.sv
module tb_tube_bcd_formatter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] show_data;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_show;

  always #5 clk = ~clk;

  tube_bcd_formatter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .show_data  (show_data),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  // Returns {ovf, show_data} from the formatting rules, using decimal
  // arithmetic rather than any shift/add procedure.
  function automatic logic [32:0] ref_fmt(input logic m, input logic [31:0] v);
    logic [31:0]     r;
    longint unsigned x;
    if (!m) return {1'b0, v};
    if (v >= 32'd100_000_000) return {1'b1, 32'hEEEE_EEEE};
    x = v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a request for exactly one rising edge, then scrambles mode and
  // bin_in so that late changes would be visible if the DUT used them.
  task automatic launch(input logic m, input logic [31:0] v);
    @(negedge clk);
    mode   = m;
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mode   = 1'($urandom_range(0, 1));
    bin_in = $urandom;
  endtask

  // Waits for done (bounded); reports the cycle count after the accepted edge
  // and whether show_data stayed at 'hold' until then.
  task automatic wait_done(input logic [31:0] hold, output int cyc, output bit held);
    cyc  = -1;
    held = 1'b1;
    for (int i = 1; i <= 100 && cyc < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) cyc = i;
      else if (show_data !== hold) held = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst    = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    bin_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (show_data !== 32'h0) begin failures++; $display("FAIL reset_show got=%h exp=%h", show_data, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    last_show = 32'h0;
  endtask

  task automatic test_hex();
    int cyc; bit held;
    launch(1'b0, 32'hDEAD_BEEF);
    wait_done(last_show, cyc, held);
    checks++; if (cyc != 1) begin failures++; $display("FAIL hex_latency got=%0d exp=1", cyc); end
    checks++; if (show_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hex_show got=%h exp=deadbeef", show_data); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL hex_ovf got=%b exp=0", ovf); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hex_busy_in_done got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hex_done_pulse got done=%b busy=%b exp 0/0", done, busy); end
    last_show = 32'hDEAD_BEEF;
  endtask

  task automatic test_decimal();
    logic [31:0] vals[5];
    logic [32:0] e;
    int cyc; bit held;
    vals = '{32'd12_345_678, 32'd99_999_999, 32'd0, 32'd1, 32'd10};
    foreach (vals[i]) begin
      e = ref_fmt(1'b1, vals[i]);
      exp_q.push_back(e[31:0]);
      launch(1'b1, vals[i]);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dec_busy v=%0d got=%b exp=1", vals[i], busy); end
      wait_done(last_show, cyc, held);
      checks++; if (cyc != 32) begin failures++; $display("FAIL dec_latency v=%0d got=%0d exp=33", vals[i], cyc + 1); end
      checks++; if (!held) begin failures++; $display("FAIL dec_hold v=%0d got=changed exp=%h", vals[i], last_show); end
      last_show = exp_q.pop_front();
      checks++; if (show_data !== last_show) begin failures++; $display("FAIL dec_show v=%0d got=%h exp=%h", vals[i], show_data, last_show); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL dec_ovf v=%0d got=%b exp=0", vals[i], ovf); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] vals[2];
    int cyc; bit held;
    vals = '{32'd100_000_000, 32'hFFFF_FFFF};
    foreach (vals[i]) begin
      launch(1'b1, vals[i]);
      wait_done(last_show, cyc, held);
      checks++; if (cyc != 1) begin failures++; $display("FAIL ovf_latency v=%h got=%0d exp=1", vals[i], cyc); end
      checks++; if (show_data !== 32'hEEEE_EEEE) begin failures++; $display("FAIL ovf_show v=%h got=%h exp=eeeeeeee", vals[i], show_data); end
      checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag v=%h got=%b exp=1", vals[i], ovf); end
      last_show = 32'hEEEE_EEEE;
    end
    // ovf stays set through the next conversion and clears with its done.
    launch(1'b1, 32'd5);
    @(negedge clk);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    wait_done(last_show, cyc, held);
    checks++; if (cyc != 32) begin failures++; $display("FAIL ovf_then5_latency got=%0d exp=33", cyc + 1); end
    checks++; if (show_data !== 32'h5) begin failures++; $display("FAIL ovf_then5_show got=%h exp=00000005", show_data); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_then5_ovf got=%b exp=0", ovf); end
    last_show = 32'h5;
  endtask

  task automatic test_start_while_busy();
    logic [31:0] v0, v1;
    logic [32:0] e;
    int cyc; bit held; int extra;
    v0 = $urandom_range(0, 99_999_999);
    v1 = v0 ^ 32'h0000_0F0F;
    e  = ref_fmt(1'b1, v0);
    launch(1'b1, v0);
    repeat (10) @(negedge clk);
    start  = 1'b1;
    mode   = 1'b0;
    bin_in = v1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(last_show, cyc, held);
    checks++; if (cyc != 22) begin failures++; $display("FAIL busy_start_latency got=%0d exp=33", cyc + 11); end
    checks++; if (show_data !== e[31:0]) begin failures++; $display("FAIL busy_start_show got=%h exp=%h", show_data, e[31:0]); end
    checks++; if (!held) begin failures++; $display("FAIL busy_start_hold got=changed exp=%h", last_show); end
    last_show = e[31:0];
    // start raised during the DONE cycle must be dropped.
    start  = 1'b1;
    mode   = 1'b0;
    bin_in = v1;
    @(negedge clk);
    start  = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_start_busy got=%b exp=0", busy); end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL done_start_extra_done got=%0d exp=0", extra); end
    checks++; if (show_data !== last_show) begin failures++; $display("FAIL done_start_show got=%h exp=%h", show_data, last_show); end
  endtask

  task automatic test_reset_mid_conv();
    logic [31:0] w;
    logic [32:0] e;
    int cyc; bit held; int seen;
    launch(1'b1, 32'd87_654_321);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (show_data !== 32'h0) begin failures++; $display("FAIL midrst_show got=%h exp=00000000", show_data); end
    checks++; if (ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_flags got ovf=%b busy=%b done=%b exp 0/0/0", ovf, busy, done); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    last_show = 32'h0;
    w = $urandom_range(0, 99_999_999);
    e = ref_fmt(1'b1, w);
    launch(1'b1, w);
    wait_done(last_show, cyc, held);
    checks++; if (cyc != 33) begin failures++; $display("FAIL midrst_conv_latency got=%0d exp=33", cyc); end
    checks++; if (show_data !== e[31:0]) begin failures++; $display("FAIL midrst_conv_show v=%0d got=%h exp=%h", w, show_data, e[31:0]); end
    last_show = e[31:0];
  endtask

  task automatic test_random();
    logic        m;
    logic [31:0] v;
    logic [32:0] e;
    int          kind, lat, cyc;
    bit          held;
    for (int n = 0; n < 1000; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        m = 1'b0; v = $urandom;
      end else if (kind == 1) begin
        m = 1'b1; v = $urandom;
      end else begin
        m = 1'b1; v = $urandom_range(0, 99_999_999);
      end
      e   = ref_fmt(m, v);
      lat = (m && v < 32'd100_000_000) ? 33 : 1;
      exp_q.push_back(e[31:0]);
      launch(m, v);
      wait_done(last_show, cyc, held);
      last_show = exp_q.pop_front();
      checks++; if (cyc != lat) begin failures++; $display("FAIL rand_latency n=%0d m=%b v=%h got=%0d exp=%0d", n, m, v, cyc, lat); end
      checks++; if (show_data !== last_show) begin failures++; $display("FAIL rand_show n=%0d m=%b v=%h got=%h exp=%h", n, m, v, show_data, last_show); end
      checks++; if (ovf !== e[32]) begin failures++; $display("FAIL rand_ovf n=%0d m=%b v=%h got=%b exp=%b", n, m, v, ovf, e[32]); end
      checks++; if (!held) begin failures++; $display("FAIL rand_hold n=%0d m=%b v=%h got=changed", n, m, v); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_start_while_busy();
    test_reset_mid_conv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
